// File: rtl/floor_request_queue_if.sv
// Request/response bundle between the call-button side and floor_request_queue.
// Carries the pos0Mem/deletePos0 pair shared with floor_comparator.
interface floor_request_queue_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FLOOR_W = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               reqValid;
  logic [FLOOR_W-1:0] reqFloor;
  logic [FLOOR_W-1:0] actualFloor;
  logic               deletePos0;
  logic [FLOOR_W-1:0] pos0Mem;
  logic               empty;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic               reqAccepted;
  logic               reqRejected;

  modport master (
    output reqValid, reqFloor, actualFloor, deletePos0,
    input  pos0Mem, empty, full, count, reqAccepted, reqRejected
  );

  modport slave (
    input  reqValid, reqFloor, actualFloor, deletePos0,
    output pos0Mem, empty, full, count, reqAccepted, reqRejected
  );
endinterface

// File: rtl/floor_request_queue.sv
// Circular queue of distinct pending floor requests; head drives pos0Mem and is
// retired on each rising edge of deletePos0.
module floor_request_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FLOOR_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  floor_request_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLOOR_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_del_prev;
  logic               r_acc;
  logic               r_rej;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_dup;
  logic               w_push;
  logic [CNT_W-1:0]   w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = bus.deletePos0 & ~r_del_prev & ~w_empty;

  // The head being popped this cycle still counts as stored for duplicate checks.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_mem[i] == bus.reqFloor)) w_dup = 1'b1;
    end
  end

  assign w_push = bus.reqValid & ~(w_full & ~w_pop) & ~w_dup
                & ~(w_empty & (bus.reqFloor == bus.actualFloor));

  assign w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, w_push}
                               - {{(CNT_W-1){1'b0}}, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_vld      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_del_prev <= 1'b1;
      r_acc      <= 1'b0;
      r_rej      <= 1'b0;
    end else begin
      r_del_prev <= bus.deletePos0;
      r_acc      <= bus.reqValid & w_push;
      r_rej      <= bus.reqValid & ~w_push;
      r_count    <= w_count_nxt;
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      // Placed after the pop so a full-queue push into the freed slot wins.
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.reqFloor;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Idle queue reflects the car's own floor so the comparator sits in stop.
  assign bus.pos0Mem     = w_empty ? bus.actualFloor : r_mem[r_rd_ptr];
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.count       = r_count;
  assign bus.reqAccepted = r_acc;
  assign bus.reqRejected = r_rej;
endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench: push responses go through a scoreboard queue checked by a
// separate monitor; queue state is checked inline after each step.
module tb_floor_request_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FLOOR_W = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic sb[$];
  logic mon_exp;

  floor_request_queue_if #(.DEPTH(DEPTH), .FLOOR_W(FLOOR_W)) bus ();

  floor_request_queue #(.DEPTH(DEPTH), .FLOOR_W(FLOOR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [FLOOR_W-1:0] f, input logic exp_acc);
    bus.reqValid = 1'b1;
    bus.reqFloor = f;
    sb.push_back(exp_acc);
    cyc();
    bus.reqValid = 1'b0;
  endtask

  task automatic push_pop(input logic [FLOOR_W-1:0] f, input logic exp_acc);
    bus.deletePos0 = 1'b1;
    push(f, exp_acc);
    bus.deletePos0 = 1'b0;
  endtask

  task automatic pop_pulse();
    bus.deletePos0 = 1'b1;
    cyc();
    bus.deletePos0 = 1'b0;
    cyc();
  endtask

  // Response monitor: each reqAccepted/reqRejected pulse must match the oldest
  // expected outcome; an encoding of {acc,rej} catches double pulses too.
  always @(negedge clk) begin
    if (rst_n && (bus.reqAccepted || bus.reqRejected)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got acc=%0d rej=%0d expected no pulse",
                 bus.reqAccepted, bus.reqRejected);
      end else begin
        mon_exp = sb.pop_front();
        chk("resp", int'({bus.reqAccepted, bus.reqRejected}), int'({mon_exp, ~mon_exp}));
      end
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.reqValid    = 1'b0;
    bus.reqFloor    = '0;
    bus.actualFloor = 3'd1;
    bus.deletePos0  = 1'b0;
    #12;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_pos0", int'(bus.pos0Mem), 1);
    chk("rst_full", int'(bus.full), 0);

    bus.deletePos0 = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("rel_count", int'(bus.count), 0);
    chk("rel_empty", int'(bus.empty), 1);
    bus.deletePos0  = 1'b0;
    bus.actualFloor = 3'd0;
    cyc();

    // Fill in order 3,1,2,0; duplicate 1 rejected when full.
    push(3'd3, 1'b1);
    chk("fill1_count", int'(bus.count), 1);
    chk("fill1_pos0", int'(bus.pos0Mem), 3);
    push(3'd1, 1'b1);
    chk("fill2_count", int'(bus.count), 2);
    push(3'd2, 1'b1);
    chk("fill3_count", int'(bus.count), 3);
    push(3'd0, 1'b1);
    chk("fill4_count", int'(bus.count), 4);
    chk("fill4_full", int'(bus.full), 1);
    push(3'd1, 1'b0);
    chk("dup_count", int'(bus.count), 4);
    chk("dup_pos0", int'(bus.pos0Mem), 3);

    // Level held 5 cycles retires exactly one entry.
    bus.deletePos0 = 1'b1;
    repeat (5) cyc();
    chk("edge_count", int'(bus.count), 3);
    chk("edge_pos0", int'(bus.pos0Mem), 1);
    bus.deletePos0 = 1'b0;
    cyc();

    // Queue {1,2,0} -> {1,2,0,5}; push of popping head 1 is rejected.
    push(3'd5, 1'b1);
    chk("refill_full", int'(bus.full), 1);
    push_pop(3'd1, 1'b0);
    chk("pp_dup_count", int'(bus.count), 3);
    chk("pp_dup_pos0", int'(bus.pos0Mem), 2);

    // {2,0,5,3} full; push 6 with a pop succeeds -> {0,5,3,6}.
    push(3'd3, 1'b1);
    push_pop(3'd6, 1'b1);
    chk("pp_acc_count", int'(bus.count), 4);
    chk("pp_acc_full", int'(bus.full), 1);
    chk("pp_acc_pos0", int'(bus.pos0Mem), 0);
    push(3'd7, 1'b0);
    chk("full_rej_count", int'(bus.count), 4);

    // Drain, checking wrap-around order.
    pop_pulse();
    chk("drain1_pos0", int'(bus.pos0Mem), 5);
    pop_pulse();
    chk("drain2_pos0", int'(bus.pos0Mem), 3);
    pop_pulse();
    chk("drain3_pos0", int'(bus.pos0Mem), 6);
    chk("drain3_count", int'(bus.count), 1);
    pop_pulse();
    chk("drain4_empty", int'(bus.empty), 1);
    chk("drain4_pos0", int'(bus.pos0Mem), 0);

    // Idle at requested floor.
    bus.actualFloor = 3'd2;
    push(3'd2, 1'b0);
    chk("idle_empty", int'(bus.empty), 1);
    chk("idle_pos0", int'(bus.pos0Mem), 2);
    push(3'd0, 1'b1);
    chk("idle_acc_pos0", int'(bus.pos0Mem), 0);
    push(3'd4, 1'b1);
    push(3'd6, 1'b1);
    chk("pre_rst_count", int'(bus.count), 3);
    cyc();

    // Asynchronous reset mid-queue.
    rst_n = 1'b0;
    #2;
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_pos0", int'(bus.pos0Mem), 2);
    cyc();
    rst_n = 1'b1;
    cyc();
    push(3'd1, 1'b1);
    chk("post_rst_pos0", int'(bus.pos0Mem), 1);
    chk("post_rst_count", int'(bus.count), 1);
    cyc(); cyc();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
